// File: rtl/mram_arb_pkg.sv
// Shared types and width helpers for the MRAM port arbiter and its read tracker.
package mram_arb_pkg;

    // Arbiter phase: normal arbitration, or waiting out write recovery.
    typedef enum logic {
        ARB    = 1'b0,
        WR_REC = 1'b1
    } arb_state_t;

    // Side that received the most recent grant.
    typedef enum logic {
        OWN_RD = 1'b0,
        OWN_WR = 1'b1
    } arb_owner_t;

    // Width of the write recovery counter (matches write_delay_config).
    localparam int REC_W = 14;

    // Default pipeline depth and run length used by the arbiter.
    localparam int READ_LAT_DEFAULT = 2;
    localparam int MAX_RUN_DEFAULT  = 4;

    // The in-flight count can reach READ_LAT, so it needs a little headroom.
    function automatic int inflight_width(input int read_lat);
        return 2 + $clog2(read_lat);
    endfunction

    // The run counter has to hold 0..max_run inclusive.
    function automatic int run_width(input int max_run);
        return $clog2(max_run + 1);
    endfunction

    localparam int INFLIGHT_W_DEFAULT = inflight_width(READ_LAT_DEFAULT);
    localparam int RUN_W_DEFAULT      = run_width(MAX_RUN_DEFAULT);

endpackage

// File: rtl/mram_rd_inflight_tracker.sv
// Tracks reads issued to the macro whose data has not yet come back.
// A READ_LAT-deep valid pipeline is fed by each accepted read; the count of
// set stages is the number of reads still in flight.
module mram_rd_inflight_tracker
    import mram_arb_pkg::*;
#(
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 2 + $clog2(READ_LAT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    output logic [CNT_W-1:0] inflight
);

    logic [READ_LAT-1:0] valid_reg;

    generate
        if (READ_LAT == 1) begin : g_single
            // Single-stage pipeline: the valid bit simply records the last cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= '0;
                end else begin
                    valid_reg <= issue;
                end
            end
        end else begin : g_multi
            // Shift the issue bit through the pipeline, one stage per cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= '0;
                end else begin
                    valid_reg <= {valid_reg[READ_LAT-2:0], issue};
                end
            end
        end
    endgenerate

    // Popcount of the valid pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + CNT_W'(valid_reg[i]);
        end
    end

endmodule

// File: rtl/mram_port_arbiter.sv
// Shares the single MRAM macro port between the write engine and the
// pipelined read engine. Grants are combinational handshakes; the macro pins
// mirror whichever request is granted. Enforces write recovery, read-to-write
// turnaround and a bounded run length per side while the other side waits.
module mram_port_arbiter
    import mram_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int READ_LAT = 2,
    parameter int MAX_RUN  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [REC_W-1:0]            write_delay_config,
    input  logic                        wr_req,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_wdata,
    output logic                        wr_gnt,
    input  logic                        rd_req,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic                        rd_gnt,
    output logic [ADDR_W-1:0]           mram_addr,
    output logic [DATA_W-1:0]           mram_wdata,
    output logic                        mram_write_en,
    output logic                        mram_read_en,
    output logic                        mram_cs,
    input  logic                        mram_ready,
    input  logic                        mram_pwr_on,
    output logic [1+$clog2(READ_LAT):0] rd_inflight,
    output logic                        busy
);

    localparam int INFLIGHT_W = 2 + $clog2(READ_LAT);
    localparam int RUN_W      = run_width(MAX_RUN);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);

    arb_state_t        state_reg, state_next;
    arb_owner_t        owner_reg, owner_next;
    arb_owner_t        gnt_side;
    logic [RUN_W-1:0]  run_cnt_reg, run_cnt_next;
    logic [REC_W-1:0]  rec_cnt_reg, rec_cnt_next;

    logic eligible;
    logic run_done;
    logic keep_owner;
    logic wr_ok;
    logic rd_ok;

    mram_rd_inflight_tracker #(
        .READ_LAT (READ_LAT),
        .CNT_W    (INFLIGHT_W)
    ) u_rd_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (rd_gnt),
        .inflight (rd_inflight)
    );

    // Eligibility and fairness terms. rst_n gates the grants so the macro pins
    // drop the instant reset is asserted, even with requests still high.
    // A side that has used up its run stands aside while the other side is
    // requesting, even if the other side is momentarily blocked by read
    // turnaround; otherwise a read stream could starve writes indefinitely.
    always_comb begin
        eligible   = rst_n && (state_reg == ARB) && mram_pwr_on && mram_ready;
        run_done   = (run_cnt_reg >= RUN_MAX);
        keep_owner = (run_cnt_reg != '0) && !run_done;
        rd_ok      = eligible && rd_req
                     && !((owner_reg == OWN_RD) && run_done && wr_req);
        wr_ok      = eligible && wr_req && (rd_inflight == '0)
                     && !((owner_reg == OWN_WR) && run_done && rd_req);
    end

    // Grant selection: on a tie, stay with the owner mid-run, else switch.
    // A zero run count (only seen after reset) hands the tie to the non-owner.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (wr_ok && rd_ok) begin
            if (keep_owner) begin
                wr_gnt = (owner_reg == OWN_WR);
                rd_gnt = (owner_reg == OWN_RD);
            end else begin
                wr_gnt = (owner_reg == OWN_RD);
                rd_gnt = (owner_reg == OWN_WR);
            end
        end else begin
            wr_gnt = wr_ok;
            rd_gnt = rd_ok;
        end
    end

    // Next-state logic for recovery, ownership and run length.
    always_comb begin
        state_next   = state_reg;
        rec_cnt_next = rec_cnt_reg;
        owner_next   = owner_reg;
        run_cnt_next = run_cnt_reg;
        gnt_side     = wr_gnt ? OWN_WR : OWN_RD;

        case (state_reg)
            ARB: begin
                if (wr_gnt && (write_delay_config != '0)) begin
                    state_next   = WR_REC;
                    rec_cnt_next = write_delay_config;
                end
            end
            WR_REC: begin
                if (rec_cnt_reg <= REC_W'(1)) begin
                    state_next   = ARB;
                    rec_cnt_next = '0;
                end else begin
                    rec_cnt_next = rec_cnt_reg - REC_W'(1);
                end
            end
            default: begin
                state_next   = ARB;
                rec_cnt_next = '0;
            end
        endcase

        if (wr_gnt || rd_gnt) begin
            if (gnt_side == owner_reg) begin
                if (!run_done) begin
                    run_cnt_next = run_cnt_reg + RUN_W'(1);
                end
            end else begin
                owner_next   = gnt_side;
                run_cnt_next = RUN_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ARB;
            rec_cnt_reg <= '0;
            owner_reg   <= OWN_RD;
            run_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rec_cnt_reg <= rec_cnt_next;
            owner_reg   <= owner_next;
            run_cnt_reg <= run_cnt_next;
        end
    end

    // Macro pins mirror the granted request; everything is zero when idle.
    always_comb begin
        mram_write_en = wr_gnt;
        mram_read_en  = rd_gnt;
        mram_cs       = wr_gnt | rd_gnt;
        mram_wdata    = wr_gnt ? wr_wdata : '0;
        mram_addr     = wr_gnt ? wr_addr : (rd_gnt ? rd_addr : '0);
        busy          = (state_reg != ARB) || (rd_inflight != '0);
    end

endmodule

// File: tb/tb_mram_port_arbiter.sv
// Self-checking bench for mram_port_arbiter: directed scenarios plus a
// randomized run checked against a cycle-count reference model.
module tb_mram_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int READ_LAT = 2;
    localparam int MAX_RUN  = 4;
    localparam int IW       = 2 + $clog2(READ_LAT);
    localparam int VW       = 6 + IW + ADDR_W + DATA_W;

    logic              clk;
    logic              rst_n;
    logic [13:0]       write_delay_config;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_wdata;
    logic              wr_gnt;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [ADDR_W-1:0] mram_addr;
    logic [DATA_W-1:0] mram_wdata;
    logic              mram_write_en;
    logic              mram_read_en;
    logic              mram_cs;
    logic              mram_ready;
    logic              mram_pwr_on;
    logic [IW-1:0]     rd_inflight;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    mram_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT),
        .MAX_RUN  (MAX_RUN)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .write_delay_config (write_delay_config),
        .wr_req             (wr_req),
        .wr_addr            (wr_addr),
        .wr_wdata           (wr_wdata),
        .wr_gnt             (wr_gnt),
        .rd_req             (rd_req),
        .rd_addr            (rd_addr),
        .rd_gnt             (rd_gnt),
        .mram_addr          (mram_addr),
        .mram_wdata         (mram_wdata),
        .mram_write_en      (mram_write_en),
        .mram_read_en       (mram_read_en),
        .mram_cs            (mram_cs),
        .mram_ready         (mram_ready),
        .mram_pwr_on        (mram_pwr_on),
        .rd_inflight        (rd_inflight),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Time is a cycle number. A write at cycle c blocks all grants until
    // cycle c+cfg+1. Reads in flight are the read grants made in the previous
    // READ_LAT cycles. Fairness is tracked as (last side, consecutive grants).
    int m_cycle   = 0;
    int m_next_ok = 0;
    int m_owner   = 0;   // 0 = read side, 1 = write side
    int m_run     = 0;
    int m_hist[$];

    function automatic int m_inflight();
        int n = 0;
        foreach (m_hist[i]) if (m_hist[i] >= m_cycle - READ_LAT) n++;
        return n;
    endfunction

    function automatic void m_predict(output bit pw, output bit pr);
        bit ok, wc, rc;
        ok = rst_n && mram_pwr_on && mram_ready && (m_cycle >= m_next_ok);
        wc = ok && wr_req && (m_inflight() == 0);
        rc = ok && rd_req;
        if (m_run >= MAX_RUN && wr_req && rd_req) begin
            if (m_owner == 1) wc = 1'b0;
            else              rc = 1'b0;
        end
        pw = 1'b0;
        pr = 1'b0;
        if (wc && rc) begin
            if (m_run > 0 && m_run < MAX_RUN) pw = (m_owner == 1);
            else                              pw = (m_owner == 0);
            pr = !pw;
        end else begin
            pw = wc;
            pr = rc;
        end
    endfunction

    initial begin : model_upd
        bit pw, pr;
        int side;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cycle   = 0;
                m_next_ok = 0;
                m_owner   = 0;
                m_run     = 0;
                m_hist.delete();
            end else begin
                m_predict(pw, pr);
                if (pw) m_next_ok = m_cycle + 1 + int'(write_delay_config);
                if (pr) m_hist.push_back(m_cycle);
                if (pw || pr) begin
                    side = pw ? 1 : 0;
                    if (side == m_owner && m_run > 0) begin
                        if (m_run < MAX_RUN) m_run++;
                    end else begin
                        m_owner = side;
                        m_run   = 1;
                    end
                end
                m_cycle++;
                while (m_hist.size() > 0 && m_hist[0] < m_cycle - READ_LAT)
                    void'(m_hist.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 32'h10; rd_addr = 32'h20; wr_wdata = 64'h1;
        @(negedge clk);
        n_checks++;
        if ({wr_gnt, rd_gnt} !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", {wr_gnt, rd_gnt});
        else n_pass++;
        n_checks++;
        if ({mram_cs, mram_write_en, mram_read_en} !== 3'b000 || mram_addr !== '0 || mram_wdata !== '0)
            $display("FAIL reset_mram got cs=%b we=%b re=%b addr=%h exp all 0", mram_cs, mram_write_en, mram_read_en, mram_addr);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || rd_inflight !== '0) $display("FAIL reset_busy got busy=%b infl=%0d exp 0/0", busy, rd_inflight);
        else n_pass++;
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_write_recovery();
        int gap = 0;
        int busy_c = 0;
        tick();
        write_delay_config = 14'd3;
        wr_req = 1'b1; wr_addr = 32'h40; wr_wdata = 64'hA5;
        rd_req = 1'b1; rd_addr = 32'h80;
        @(negedge clk);
        $display("wr addr=%h data=%h gnt=%b", mram_addr, mram_wdata, wr_gnt);
        n_checks++;
        if ({wr_gnt, rd_gnt, mram_write_en, mram_cs} !== 4'b1011 || mram_addr !== 32'h40 || mram_wdata !== 64'hA5)
            $display("FAIL wrrec_write got gnt=%b%b we=%b addr=%h data=%h exp 10/1/40/a5",
                     wr_gnt, rd_gnt, mram_write_en, mram_addr, mram_wdata);
        else n_pass++;
        tick();
        wr_req = 1'b0;
        for (int k = 1; k <= 20 && gap == 0; k++) begin
            @(negedge clk);
            if (rd_gnt || wr_gnt) gap = k;
            else begin
                if (busy) busy_c++;
                tick();
            end
        end
        $display("rd addr=%h after gap=%0d", mram_addr, gap);
        n_checks++;
        if (gap !== 4) $display("FAIL wrrec_gap got=%0d exp=4", gap);
        else n_pass++;
        n_checks++;
        if (busy_c !== 3) $display("FAIL wrrec_busy got=%0d exp=3", busy_c);
        else n_pass++;
        n_checks++;
        if (rd_gnt !== 1'b1 || mram_read_en !== 1'b1 || mram_addr !== 32'h80)
            $display("FAIL wrrec_read got rg=%b re=%b addr=%h exp 1/1/80", rd_gnt, mram_read_en, mram_addr);
        else n_pass++;
        tick();
        rd_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_read_stream();
        int exp_i;
        int exp_tail[3] = '{2, 1, 0};
        write_delay_config = 14'd0;
        for (int i = 0; i < 8; i++) begin
            rd_req = 1'b1;
            rd_addr = 32'h1000 + 32'(8 * i);
            @(negedge clk);
            exp_i = (i < READ_LAT) ? i : READ_LAT;
            $display("rd beat %0d addr=%h infl=%0d", i, mram_addr, rd_inflight);
            n_checks++;
            if (rd_gnt !== 1'b1 || mram_read_en !== 1'b1 || mram_addr !== rd_addr || int'(rd_inflight) != exp_i)
                $display("FAIL stream_beat%0d got rg=%b re=%b addr=%h infl=%0d exp 1/1/%h/%0d",
                         i, rd_gnt, mram_read_en, mram_addr, rd_inflight, rd_addr, exp_i);
            else n_pass++;
            tick();
        end
        rd_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if (int'(rd_inflight) != exp_tail[j])
                $display("FAIL stream_drain%0d got=%0d exp=%0d", j, rd_inflight, exp_tail[j]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g;
        int p;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 32'hA000; rd_addr = 32'hB000; wr_wdata = 64'h5;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            p = i % 10;
            exp_g = (p < 4) ? 2'b10 : ((p < 8) ? 2'b01 : 2'b00);
            $display("fair cyc %0d wg=%b rg=%b", i, wr_gnt, rd_gnt);
            n_checks++;
            if ({wr_gnt, rd_gnt} !== exp_g)
                $display("FAIL fair_cyc%0d got=%b exp=%b", i, {wr_gnt, rd_gnt}, exp_g);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_ready_stall();
        mram_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({wr_gnt, rd_gnt, mram_write_en, mram_read_en, mram_cs} !== 5'b0 || mram_addr !== '0 || mram_wdata !== '0)
                $display("FAIL stall_cyc%0d got g=%b%b cs=%b addr=%h exp all 0", i, wr_gnt, rd_gnt, mram_cs, mram_addr);
            else n_pass++;
            tick();
        end
        mram_ready = 1'b1;
        @(negedge clk);
        $display("stall resume wg=%b rg=%b", wr_gnt, rd_gnt);
        n_checks++;
        if ({wr_gnt, rd_gnt} !== 2'b10 || mram_addr !== 32'hA000)
            $display("FAIL stall_resume got=%b addr=%h exp=10/a000", {wr_gnt, rd_gnt}, mram_addr);
        else n_pass++;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_recovery();
        int grants = 0;
        write_delay_config = 14'd100;
        wr_req = 1'b1; wr_addr = 32'h300;
        @(negedge clk);
        n_checks++;
        if (wr_gnt !== 1'b1) $display("FAIL midrst_write got=%b exp=1", wr_gnt);
        else n_pass++;
        tick();
        wr_req = 1'b0;
        rd_req = 1'b1; rd_addr = 32'h444;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wr_gnt || rd_gnt) grants++;
            tick();
        end
        n_checks++;
        if (grants !== 0 || busy !== 1'b1) $display("FAIL midrst_hold got grants=%0d busy=%b exp 0/1", grants, busy);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wr_gnt, rd_gnt, mram_cs, busy} !== 4'b0 || mram_addr !== '0 || rd_inflight !== '0)
            $display("FAIL midrst_outputs got g=%b%b cs=%b busy=%b addr=%h exp all 0", wr_gnt, rd_gnt, mram_cs, busy, mram_addr);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        $display("post-reset rd gnt=%b addr=%h", rd_gnt, mram_addr);
        n_checks++;
        if (rd_gnt !== 1'b1 || mram_addr !== 32'h444)
            $display("FAIL midrst_read got rg=%b addr=%h exp 1/444", rd_gnt, mram_addr);
        else n_pass++;
        tick();
        rd_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_cfg_change();
        int gap1 = 0;
        int gap2 = 0;
        write_delay_config = 14'd3;
        wr_req = 1'b1; wr_addr = 32'h500; wr_wdata = 64'h77;
        @(negedge clk);
        n_checks++;
        if (wr_gnt !== 1'b1) $display("FAIL cfgchg_first got=%b exp=1", wr_gnt);
        else n_pass++;
        tick();
        write_delay_config = 14'd50;
        for (int k = 1; k <= 100 && gap1 == 0; k++) begin
            @(negedge clk);
            if (wr_gnt) gap1 = k;
            else tick();
        end
        n_checks++;
        if (gap1 !== 4) $display("FAIL cfgchg_gap3 got=%0d exp=4", gap1);
        else n_pass++;
        tick();
        for (int k = 1; k <= 100 && gap2 == 0; k++) begin
            @(negedge clk);
            if (wr_gnt) gap2 = k;
            else tick();
        end
        $display("cfg change gaps %0d %0d", gap1, gap2);
        n_checks++;
        if (gap2 !== 51) $display("FAIL cfgchg_gap50 got=%0d exp=51", gap2);
        else n_pass++;
        tick();
        wr_req = 1'b0;
        write_delay_config = 14'd0;
    endtask

    task automatic test_random();
        bit pw, pr;
        int infl;
        logic [VW-1:0] exp_v, got_v;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        for (int i = 0; i < 300; i++) begin
            wr_req      = ($urandom_range(0, 9) < 6);
            rd_req      = ($urandom_range(0, 9) < 6);
            mram_ready  = ($urandom_range(0, 9) < 9);
            mram_pwr_on = ($urandom_range(0, 19) < 19);
            write_delay_config = 14'($urandom_range(0, 3));
            wr_addr  = $urandom;
            rd_addr  = $urandom;
            wr_wdata = {$urandom, $urandom};
            @(negedge clk);
            m_predict(pw, pr);
            infl = m_inflight();
            ea = pw ? wr_addr : (pr ? rd_addr : '0);
            ed = pw ? wr_wdata : '0;
            exp_v = {pw, pr, pw, pr, pw | pr, (m_cycle < m_next_ok) || (infl != 0), IW'(infl), ea, ed};
            got_v = {wr_gnt, rd_gnt, mram_write_en, mram_read_en, mram_cs, busy, rd_inflight, mram_addr, mram_wdata};
            if (pw || pr) $display("rand %0d: %s addr=%h", i, pw ? "WR" : "RD", ea);
            n_checks++;
            if (got_v !== exp_v) $display("FAIL rand_cyc%0d got=%h exp=%h", i, got_v, exp_v);
            else n_pass++;
            tick();
        end
        wr_req = 1'b0; rd_req = 1'b0;
        mram_ready = 1'b1; mram_pwr_on = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        write_delay_config = 14'd0;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_wdata = '0;
        mram_ready = 1'b1; mram_pwr_on = 1'b1;
        test_reset();
        test_write_recovery();
        test_read_stream();
        test_fairness();
        test_ready_stall();
        test_reset_mid_recovery();
        test_cfg_change();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
